// File: rtl/regfile_wb_arbiter.sv
// Write-port sequencer for RegisterBank: zero-sweeps x1..x(NUM_REGS-1) after reset,
// then round-robin arbitrates ALU (A) and LSU (B) writebacks onto the single write port.
module regfile_wb_arbiter #(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 32,
  parameter int NUM_REGS       = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              write_ena,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              init_done
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_REG    = ADDR_W'(NUM_REGS - 1);
  localparam state_t            RESET_STATE = CLEAR_ON_RESET ? INIT : RUN;

  state_t            state;
  state_t            state_next;
  logic              rr_ptr;  // 0: A wins a tie, 1: B wins a tie
  logic [ADDR_W-1:0] cnt;
  logic              grant_a;
  logic              grant_b;

  always_ff @(posedge clk) begin
    if (rst) state <= RESET_STATE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == INIT && cnt == LAST_REG) state_next = RUN;
  end

  // Readies are masked during rst so nothing is accepted on a reset edge.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == RUN && !rst) begin
      grant_a = a_valid && (!b_valid || !rr_ptr);
      grant_b = b_valid && (!a_valid ||  rr_ptr);
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      write_ena <= 1'b0;
      rd_addr   <= '0;
      rd_data   <= '0;
      init_done <= 1'b0;
      rr_ptr    <= 1'b0;
      cnt       <= ADDR_W'(1);
    end else begin
      case (state)
        INIT: begin
          write_ena <= 1'b1;
          rd_addr   <= cnt;
          rd_data   <= '0;
          cnt       <= cnt + ADDR_W'(1);
          if (cnt == LAST_REG) init_done <= 1'b1;
        end
        default: begin
          init_done <= 1'b1;
          write_ena <= 1'b0;
          // A write to x0 still completes the handshake but never reaches the bank.
          if (grant_a) begin
            rr_ptr <= 1'b1;
            if (a_addr != '0) begin
              write_ena <= 1'b1;
              rd_addr   <= a_addr;
              rd_data   <= a_data;
            end
          end else if (grant_b) begin
            rr_ptr <= 1'b0;
            if (b_addr != '0) begin
              write_ena <= 1'b1;
              rd_addr   <= b_addr;
              rd_data   <= b_data;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: queued source requests, a behavioural
// arbiter/register-bank model, and a monitor comparing each cycle's write-port output.
module tb_regfile_wb_arbiter;

  localparam int NR = 32;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } req_t;

  typedef struct packed {
    bit          we;
    bit          chk_ad;
    bit          done;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [4:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        a_ready, b_ready, write_ena, init_done;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        u1_a_ready, u1_b_ready, u1_we, u1_done;
  logic [4:0]  u1_addr;
  logic [31:0] u1_data;

  regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .NUM_REGS(NR), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .write_ena(write_ena), .rd_addr(rd_addr), .rd_data(rd_data), .init_done(init_done)
  );

  regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .NUM_REGS(NR), .CLEAR_ON_RESET(1'b0)) u1 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(u1_a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(u1_b_ready), .b_addr(b_addr), .b_data(b_data),
    .write_ena(u1_we), .rd_addr(u1_addr), .rd_data(u1_data), .init_done(u1_done)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  req_t        qa[$], qb[$];
  exp_t        sb[$];
  bit          glog[$];
  logic [31:0] bank [NR];
  logic [31:0] mbank[NR];
  bit          m_init;
  int          m_k;
  bit          m_rr;
  int          u1_probe = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Emulated RegisterBank plus output monitor.
  always @(posedge clk) begin
    exp_t e;
    if (write_ena === 1'b1 && rd_addr != 5'd0) bank[rd_addr] = rd_data;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("write_ena", 32'(write_ena), 32'(e.we));
      chk("init_done", 32'(init_done), 32'(e.done));
      if (e.chk_ad) begin
        chk("rd_addr", 32'(rd_addr), 32'(e.addr));
        chk("rd_data", rd_data, e.data);
      end
    end
  end

  // One clock: drive from the source queues, predict, check readies, queue the expected output.
  task automatic step(input bit r);
    bit   ga, gb;
    exp_t e;
    req_t w;
    rst     = r;
    a_valid = (qa.size() > 0);
    b_valid = (qb.size() > 0);
    if (a_valid) begin a_addr = qa[0].addr; a_data = qa[0].data; end
    if (b_valid) begin b_addr = qb[0].addr; b_data = qb[0].data; end
    #1;
    ga = 1'b0;
    gb = 1'b0;
    e  = '0;
    if (r) begin
      m_init   = 1'b1;
      m_k      = 1;
      m_rr     = 1'b0;
      e.chk_ad = 1'b1;
      chk("u1_ready_in_rst", 32'(u1_a_ready | u1_b_ready), 32'd0);
    end else if (m_init) begin
      e.we     = 1'b1;
      e.chk_ad = 1'b1;
      e.addr   = 5'(m_k);
      e.done   = (m_k == NR - 1);
      mbank[m_k] = '0;
      if (m_k == NR - 1) m_init = 1'b0;
      m_k++;
    end else begin
      ga = a_valid && (!b_valid || m_rr == 1'b0);
      gb = b_valid && (!a_valid || m_rr == 1'b1);
      e.done = 1'b1;
      if (ga || gb) begin
        w = ga ? qa[0] : qb[0];
        m_rr = ga;
        glog.push_back(gb);
        if (w.addr != 5'd0) begin
          e.we = 1'b1; e.chk_ad = 1'b1; e.addr = w.addr; e.data = w.data;
          mbank[w.addr] = w.data;
        end
      end
    end
    chk("a_ready", 32'(a_ready), 32'(ga));
    chk("b_ready", 32'(b_ready), 32'(gb));
    if (u1_probe == 1) begin
      chk("u1_a_ready_after_release", 32'(u1_a_ready), 32'd1);
      chk("u1_init_done_before", 32'(u1_done), 32'd0);
    end else if (u1_probe == 2) begin
      chk("u1_init_done_after", 32'(u1_done), 32'd1);
      chk("u1_write", {u1_we, 26'd0, u1_addr}, {1'b1, 26'd0, 5'd6});
      chk("u1_data", u1_data, 32'h66);
    end
    sb.push_back(e);
    @(posedge clk);
    if (ga) void'(qa.pop_front());
    if (gb) void'(qb.pop_front());
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (qa.size() > 0 || qb.size() > 0); i++) step(1'b0);
    chk("drain_pending", 32'(qa.size() + qb.size()), 32'd0);
    step(1'b0);
    step(1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    for (int i = 0; i < NR; i++) begin
      bank[i]  = (i == 0) ? 32'd0 : (32'hBAD0_0000 | 32'(i));
      mbank[i] = bank[i];
    end
    m_init = 1'b1; m_k = 1; m_rr = 1'b0;
    @(negedge clk);

    // Reset sweep, with an A request already waiting at release.
    qa.push_back('{5'd6, 32'h66});
    step(1'b1);
    step(1'b1);
    u1_probe = 1; step(1'b0);
    u1_probe = 2; step(1'b0);
    u1_probe = 0;
    repeat (NR - 3) step(1'b0);
    drain();
    for (int i = 1; i < NR; i++)
      chk($sformatf("sweep_x%0d", i), bank[i], (i == 6) ? 32'h66 : 32'd0);

    // Single source.
    qa.push_back('{5'd5, 32'h1234_5678});
    drain();
    chk("x5", bank[5], 32'h1234_5678);

    // Contention starting from rr pointing at A.
    qb.push_back('{5'd9, 32'h99});
    drain();
    glog.delete();
    repeat (2) begin
      qa.push_back('{5'd3, 32'hAAAA_0001});
      qb.push_back('{5'd4, 32'hBBBB_0002});
    end
    drain();
    chk("contention_grants", 32'(glog.size()), 32'd4);
    if (glog.size() == 4) begin
      pat = {glog[0], glog[1], glog[2], glog[3]};
      chk("contention_order", 32'(pat), 32'(4'b0101));
    end
    chk("x3", bank[3], 32'hAAAA_0001);
    chk("x4", bank[4], 32'hBBBB_0002);

    // Same address with rr pointing at B: B first, A last wins.
    qa.push_back('{5'd8, 32'h88});
    drain();
    qa.push_back('{5'd7, 32'h1});
    qb.push_back('{5'd7, 32'h2});
    drain();
    chk("x7_same_addr", bank[7], 32'h1);

    // x0 filter.
    glog.delete();
    qb.push_back('{5'd0, 32'hDEAD_BEEF});
    drain();
    chk("x0_handshake", 32'(glog.size()), 32'd1);
    chk("x0", bank[0], 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      if (qa.size() < 2 && $urandom_range(1) == 1)
        qa.push_back('{5'($urandom_range(NR - 1)), $urandom});
      if (qb.size() < 2 && $urandom_range(1) == 1)
        qb.push_back('{5'($urandom_range(NR - 1)), $urandom});
      step(1'b0);
    end
    drain();
    for (int i = 0; i < NR; i++)
      chk($sformatf("bank_x%0d", i), bank[i], mbank[i]);

    // Reset in the middle of the sweep.
    step(1'b1);
    repeat (10) step(1'b0);
    chk("mid_sweep_addr", 32'(rd_addr), 32'd10);
    step(1'b1);
    chk("rst_outputs", {write_ena, init_done, 25'd0, rd_addr}, 32'd0);
    repeat (NR - 1) step(1'b0);
    chk("resweep_done", 32'(init_done), 32'd1);

    @(posedge clk);
    #3;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
